traffic_phase_scheduler: RTL and testbench

Demand-actuated phase scheduler for the four-way intersection. Samples per-approach vehicle requests and grants green to one approach at a time in round-robin order (N→S→E→W), skipping approaches with no demand. Enforces minimum and maximum green, yellow and all-red clearance times. Drives the same one-hot lamp encoding as the fixed-time controller, so it can replace that controller as the intersection's lamp sequencer.

---
 rtl/traffic_phase_scheduler.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated round-robin lamp sequencer for a four-way intersection (N,S,E,W).
// Optional emergency preemption is compiled in with `define TPS_PREEMPT_EN.
module traffic_phase_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW    = 4,
   parameter int ALLRED    = 1
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic [3:0] req,
`ifdef TPS_PREEMPT_EN
   input  logic       emerg,
   input  logic [1:0] emerg_dir,
`endif
   output logic [2:0] n_lights,
   output logic [2:0] s_lights,
   output logic [2:0] e_lights,
   output logic [2:0] w_lights,
   output logic [1:0] green_dir,
   output logic       busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GREEN  = 2'd1;
   localparam logic [1:0] S_YELLOW = 2'd2;
   localparam logic [1:0] S_ALLRED = 2'd3;

   localparam logic [2:0] LAMP_G = 3'b001;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_R = 3'b100;

   localparam logic [3:0] GMIN_M1 = 4'(GREEN_MIN - 1);
   localparam logic [3:0] GMAX_M1 = 4'(GREEN_MAX - 1);
   localparam logic [3:0] YEL_M1  = 4'(YELLOW - 1);
   localparam logic [3:0] AR_M1   = 4'(ALLRED - 1);

   logic [1:0] state, state_nx;
   logic [1:0] cur, cur_nx;
   logic [3:0] cnt, cnt_nx;
   logic       pre_req;
   logic [1:0] pre_dir;
   logic       others;
   logic       gap_out;
   logic       max_out;
   logic [3:0] cnt_sat;

`ifdef TPS_PREEMPT_EN
   assign pre_req = emerg;
   assign pre_dir = emerg_dir;
`else
   assign pre_req = 1'b0;
   assign pre_dir = 2'd0;
`endif

   // First requester after c in N->S->E->W order; c itself only as last resort.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] c);
      logic [1:0] idx;
      rr_pick = c;
      for (int i = 3; i >= 1; i--) begin
         idx = c + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [2:0] lamp(input logic [1:0] st, input logic [1:0] c,
                                       input logic [1:0] dir);
      lamp = LAMP_R;
      if (c == dir && st == S_GREEN)  lamp = LAMP_G;
      if (c == dir && st == S_YELLOW) lamp = LAMP_Y;
   endfunction

   assign others  = |(req & ~(4'b0001 << cur));
   assign gap_out = (cnt >= GMIN_M1) && !req[cur];
   assign max_out = (cnt >= GMAX_M1);
   assign cnt_sat = (cnt < GMAX_M1) ? cnt + 4'd1 : cnt;

   always_comb begin
      state_nx = state;
      cur_nx   = cur;
      cnt_nx   = cnt;
      case (state)
         S_IDLE, S_ALLRED: begin
            if (state == S_ALLRED && cnt != AR_M1) begin
               cnt_nx = cnt + 4'd1;
            end else if (pre_req) begin
               state_nx = S_GREEN;
               cur_nx   = pre_dir;
               cnt_nx   = 4'd0;
            end else if (|req) begin
               state_nx = S_GREEN;
               cur_nx   = rr_pick(req, cur);
               cnt_nx   = 4'd0;
            end else begin
               state_nx = S_IDLE;
               cnt_nx   = 4'd0;
            end
         end
         S_GREEN: begin
            // An emergency for the approach already green pins it there.
            if (pre_req && pre_dir == cur) begin
               cnt_nx = cnt_sat;
            end else if (pre_req || (others && (gap_out || max_out))) begin
               state_nx = S_YELLOW;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt_sat;
            end
         end
         S_YELLOW: begin
            if (cnt == YEL_M1) begin
               state_nx = S_ALLRED;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Lamps are registered from next-state so they switch on the same edge as state.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         state     <= S_IDLE;
         cur       <= 2'd3;
         cnt       <= 4'd0;
         n_lights  <= LAMP_R;
         s_lights  <= LAMP_R;
         e_lights  <= LAMP_R;
         w_lights  <= LAMP_R;
         green_dir <= 2'd3;
         busy      <= 1'b0;
      end else begin
         state    <= state_nx;
         cur      <= cur_nx;
         cnt      <= cnt_nx;
         n_lights <= lamp(state_nx, cur_nx, 2'd0);
         s_lights <= lamp(state_nx, cur_nx, 2'd1);
         e_lights <= lamp(state_nx, cur_nx, 2'd2);
         w_lights <= lamp(state_nx, cur_nx, 2'd3);
         if (state_nx == S_GREEN || state_nx == S_YELLOW) green_dir <= cur_nx;
         busy     <= (state_nx != S_IDLE);
      end
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler at default timing parameters.
// The preemption scenario is exercised when TPS_PREEMPT_EN is defined.
module tb_traffic_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst_a;
   logic [3:0] req;
   logic       emerg;
   logic [1:0] emerg_dir;
   logic [2:0] n_lights, s_lights, e_lights, w_lights;
   logic [1:0] green_dir;
   logic       busy;

   localparam logic [2:0]  G = 3'b001;
   localparam logic [2:0]  Y = 3'b010;
   localparam logic [2:0]  R = 3'b100;
   localparam logic [11:0] ALL_RED = 12'h924;

   int n_cmp = 0;
   int n_bad = 0;

   traffic_phase_scheduler dut (
      .clk       (clk),
      .rst_a     (rst_a),
      .req       (req),
`ifdef TPS_PREEMPT_EN
      .emerg     (emerg),
      .emerg_dir (emerg_dir),
`endif
      .n_lights  (n_lights),
      .s_lights  (s_lights),
      .e_lights  (e_lights),
      .w_lights  (w_lights),
      .green_dir (green_dir),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] lamp_of(input int d);
      case (d)
         0:       lamp_of = n_lights;
         1:       lamp_of = s_lights;
         2:       lamp_of = e_lights;
         default: lamp_of = w_lights;
      endcase
   endfunction

   // Counts cycles (including the current one) that approach d shows code.
   task automatic run_len(input int d, input logic [2:0] code, output int len);
      len = 0;
      while (lamp_of(d) == code && len < 200) begin
         len++;
         step();
      end
   endtask

   task automatic run_red(output int len);
      len = 0;
      while ({n_lights, s_lights, e_lights, w_lights} == ALL_RED && len < 200) begin
         len++;
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      int len;
      int bad;
      int total;
      rst_a = 1'b1; req = 4'b0000; emerg = 1'b0; emerg_dir = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lamps", {n_lights, s_lights, e_lights, w_lights}, ALL_RED);
      check("rst_gdir", green_dir, 2'd3);
      check("rst_busy", busy, 1'b0);
      rst_a = 1'b0;
      step();
      check("idle_lamps", {n_lights, s_lights, e_lights, w_lights}, ALL_RED);

      // N only: granted on the first edge, then rests
      req = 4'b0001;
      step();
      check("n_grant", n_lights, G);
      check("n_grant_rest", {s_lights, e_lights, w_lights}, 9'b100100100);
      check("n_busy", busy, 1'b1);
      check("n_gdir", green_dir, 2'd0);
      bad = 0;
      for (int i = 0; i < 49; i++) begin
         step();
         if (n_lights != G || busy != 1'b1) bad++;
      end
      check("n_rest_50", bad, 0);

      // E joins: N maxes out immediately, S skipped
      req = 4'b0101;
      step();
      check("n_to_yel", n_lights, Y);
      run_len(0, Y, len);
      check("n_yel_len", len, 4);
      check("allred", {n_lights, s_lights, e_lights, w_lights}, ALL_RED);
      run_red(len);
      check("allred_len", len, 1);
      check("e_grant", e_lights, G);
      check("s_skipped", s_lights, R);
      check("e_gdir", green_dir, 2'd2);

      // E max-out with N waiting, then N gap-out at GREEN_MIN
      run_len(2, G, len);
      check("e_max_len", len, 8);
      run_len(2, Y, len);
      check("e_yel_len", len, 4);
      run_red(len);
      check("e_red_len", len, 1);
      check("n_grant2", n_lights, G);
      req = 4'b0100;
      run_len(0, G, len);
      check("n_gap_len", len, 4);
      check("n_gap_yel", n_lights, Y);

      // Full demand: round robin N,S,E,W with 13-cycle phases
      req = 4'b1111;
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      step();
      total = 0;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("rr_gdir%0d", d), green_dir, d);
         run_len(d, G, len);
         check($sformatf("rr_grn%0d", d), len, 8);
         total += len;
         run_len(d, Y, len);
         check($sformatf("rr_yel%0d", d), len, 4);
         total += len;
         run_red(len);
         check($sformatf("rr_red%0d", d), len, 1);
         total += len;
      end
      check("rr_wrap_n", n_lights, G);
      check("rr_period", total, 52);

      // Async reset during S yellow
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      step();
      run_len(0, G, len);
      run_len(0, Y, len);
      run_red(len);
      run_len(1, G, len);
      step();
      check("s_yel_pre", s_lights, Y);
      rst_a = 1'b1;
      #1;
      check("arst_lamps", {n_lights, s_lights, e_lights, w_lights}, ALL_RED);
      check("arst_busy", busy, 1'b0);
      check("arst_gdir", green_dir, 2'd3);
      #1;
      rst_a = 1'b0;
      step();
      check("arst_n_grant", n_lights, G);
      check("arst_n_gdir", green_dir, 2'd0);

`ifdef TPS_PREEMPT_EN
      // E green cycle 2, emergency for W cuts E short
      req = 4'b0100;
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      step();
      check("pe_e_grant", e_lights, G);
      step();
      emerg = 1'b1;
      emerg_dir = 2'd3;
      step();
      check("pe_e_yel", e_lights, Y);
      run_len(2, Y, len);
      check("pe_yel_len", len, 4);
      run_red(len);
      check("pe_red_len", len, 1);
      check("pe_w_grant", w_lights, G);
      check("pe_w_gdir", green_dir, 2'd3);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (w_lights != G) bad++;
      end
      check("pe_w_hold", bad, 0);
      emerg = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
